// File: rtl/hex_scan_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module   : hex_scan_decoder_if
//  Brief    : Display-bus bundle between a multiplexed 7-segment source
//             (master) and the scan decoder (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface hex_scan_decoder_if #(
    parameter int N_DIGITS = 4
);
    logic [6:0]            seg_n;        // active-low segments, bit0 = a .. bit6 = g
    logic [N_DIGITS-1:0]   dig_n;        // active-low digit selects
    logic [4*N_DIGITS-1:0] code;         // decoded word, digit i at [4i+3:4i]
    logic [N_DIGITS-1:0]   err;          // per-digit illegal-glyph flags
    logic                  frame_valid;  // one-cycle update strobe

    // Display source side: drives the pins, observes the decoded result
    modport master (
        output seg_n,
        output dig_n,
        input  code,
        input  err,
        input  frame_valid
    );

    // Decoder side
    modport slave (
        input  seg_n,
        input  dig_n,
        output code,
        output err,
        output frame_valid
    );
endinterface
`default_nettype wire

// File: rtl/hex_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : hex_scan_decoder
//  Brief    : Snoops a time-multiplexed active-low 7-segment display bus and
//             recovers the hex nibble behind every digit. A digit is accepted
//             once its registered pattern has been stable long enough; a full
//             word is published with a one-cycle frame_valid strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module hex_scan_decoder #(
    parameter int N_DIGITS = 4,   // 1..8
    parameter int STABLE   = 16   // >= 2
) (
    input  logic             clk,
    input  logic             rst,
    hex_scan_decoder_if.slave bus
);

    localparam int             CW        = $clog2(STABLE);
    localparam logic [CW-1:0]  C_CNT_MAX = CW'(STABLE - 1);

    typedef enum logic [0:0] {
        SETTLE = 1'b0,   // waiting for a pattern to become stable
        HOLD   = 1'b1    // current pattern already accepted
    } state_t;

    // Registered state
    logic [6:0]            seg_q, seg_d;
    logic [N_DIGITS-1:0]   dig_q, dig_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    state_t                state_q, state_d;
    logic [N_DIGITS-1:0]   mask_q, mask_d;
    logic [4*N_DIGITS-1:0] shadow_code_q, shadow_code_d;
    logic [N_DIGITS-1:0]   shadow_err_q, shadow_err_d;
    logic [4*N_DIGITS-1:0] code_q, code_d;
    logic [N_DIGITS-1:0]   err_q, err_d;
    logic                  frame_valid_q, frame_valid_d;

    // Combinational helpers
    logic                  w_changed;
    logic                  w_sel_ok;
    logic [N_DIGITS-1:0]   w_sel;
    logic [3:0]            w_nibble;
    logic                  w_illegal;
    logic                  w_capture;

    // Input stage: register the pins and track how long they have held still
    always_comb begin
        seg_d     = bus.seg_n;
        dig_d     = bus.dig_n;
        w_changed = ({bus.seg_n, bus.dig_n} != {seg_q, dig_q});
        if (w_changed) begin
            cnt_d = '0;
        end else if (cnt_q == C_CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Digit select is usable only when exactly one select line is low
    always_comb begin
        w_sel    = ~dig_q;
        w_sel_ok = $onehot(w_sel);
    end

    // Glyph lookup on the active-high view of the registered segments
    always_comb begin
        w_nibble  = 4'h0;
        w_illegal = 1'b0;
        case (~seg_q)
            7'h3F: w_nibble = 4'h0;
            7'h06: w_nibble = 4'h1;
            7'h5B: w_nibble = 4'h2;
            7'h4F: w_nibble = 4'h3;
            7'h66: w_nibble = 4'h4;
            7'h6D: w_nibble = 4'h5;
            7'h7D: w_nibble = 4'h6;
            7'h07: w_nibble = 4'h7;
            7'h7F: w_nibble = 4'h8;
            7'h6F: w_nibble = 4'h9;
            7'h77: w_nibble = 4'hA;
            7'h7C: w_nibble = 4'hB;
            7'h39: w_nibble = 4'hC;
            7'h5E: w_nibble = 4'hD;
            7'h79: w_nibble = 4'hE;
            7'h71: w_nibble = 4'hF;
            default: w_illegal = 1'b1;
        endcase
    end

    // Acceptance FSM: capture once per stable pattern. The pins must also be
    // unchanged on the capture edge so a digit needs STABLE+1 cycles of dwell.
    always_comb begin
        state_d   = state_q;
        w_capture = 1'b0;
        case (state_q)
            SETTLE: begin
                if ((cnt_q == C_CNT_MAX) && !w_changed && w_sel_ok) begin
                    state_d   = HOLD;
                    w_capture = 1'b1;
                end
            end
            HOLD: begin
                if (w_changed) begin
                    state_d = SETTLE;
                end
            end
            default: state_d = SETTLE;
        endcase
    end

    // Shadow/mask bookkeeping and frame publication; a capture on the
    // publishing edge lands in the fresh mask for the next frame
    always_comb begin
        shadow_code_d = shadow_code_q;
        shadow_err_d  = shadow_err_q;
        mask_d        = mask_q;
        code_d        = code_q;
        err_d         = err_q;
        frame_valid_d = 1'b0;
        if (&mask_q) begin
            code_d        = shadow_code_q;
            err_d         = shadow_err_q;
            frame_valid_d = 1'b1;
            mask_d        = '0;
        end
        for (int i = 0; i < N_DIGITS; i++) begin
            if (w_capture && w_sel[i]) begin
                shadow_code_d[4*i +: 4] = w_nibble;
                shadow_err_d[i]         = w_illegal;
                mask_d[i]               = 1'b1;
            end
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q         <= 7'h7F;
            dig_q         <= '1;
            cnt_q         <= '0;
            state_q       <= SETTLE;
            mask_q        <= '0;
            shadow_code_q <= '0;
            shadow_err_q  <= '0;
            code_q        <= '0;
            err_q         <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            seg_q         <= seg_d;
            dig_q         <= dig_d;
            cnt_q         <= cnt_d;
            state_q       <= state_d;
            mask_q        <= mask_d;
            shadow_code_q <= shadow_code_d;
            shadow_err_q  <= shadow_err_d;
            code_q        <= code_d;
            err_q         <= err_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign bus.code        = code_q;
    assign bus.err         = err_q;
    assign bus.frame_valid = frame_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hex_scan_decoder
//  Brief    : Directed self-checking bench for hex_scan_decoder: a 4-digit
//             instance for frame behaviour and a 1-digit instance for the
//             full glyph round trip.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hex_scan_decoder;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hex_scan_decoder_if #(.N_DIGITS(4)) bus4 ();
    hex_scan_decoder_if #(.N_DIGITS(1)) bus1 ();

    hex_scan_decoder #(.N_DIGITS(4), .STABLE(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    hex_scan_decoder #(.N_DIGITS(1), .STABLE(4)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int p4       = 0;
    int p1       = 0;
    int fv4_cyc  = 0;
    int c0       = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference encoder: active-high segments g..a for each nibble
    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0: glyph = 7'b0111111;
            4'h1: glyph = 7'b0000110;
            4'h2: glyph = 7'b1011011;
            4'h3: glyph = 7'b1001111;
            4'h4: glyph = 7'b1100110;
            4'h5: glyph = 7'b1101101;
            4'h6: glyph = 7'b1111101;
            4'h7: glyph = 7'b0000111;
            4'h8: glyph = 7'b1111111;
            4'h9: glyph = 7'b1101111;
            4'hA: glyph = 7'b1110111;
            4'hB: glyph = 7'b1111100;
            4'hC: glyph = 7'b0111001;
            4'hD: glyph = 7'b1011110;
            4'hE: glyph = 7'b1111001;
            default: glyph = 7'b1110001;
        endcase
    endfunction

    // Advance one clock, sample 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (bus4.frame_valid) begin
            p4++;
            fv4_cyc = cyc;
        end
        if (bus1.frame_valid) p1++;
    endtask

    task automatic show4(input int d, input logic [6:0] seg_hi, input int n);
        bus4.seg_n = ~seg_hi;
        bus4.dig_n = ~(4'b0001 << d);
        repeat (n) step();
    endtask

    initial begin
        rst        = 1'b1;
        bus4.seg_n = 7'h7F;
        bus4.dig_n = 4'hF;
        bus1.seg_n = 7'h7F;
        bus1.dig_n = 1'b1;
        repeat (3) step();

        // Reset state
        check("rst_code", bus4.code, 32'h0);
        check("rst_err", bus4.err, 32'h0);
        check("rst_fv", bus4.frame_valid, 32'h0);
        check("rst_cnt", dut4.cnt_q, 32'h0);
        rst = 1'b0;
        step();

        // 1: basic frame 1,2,3,4
        p4 = 0;
        show4(0, glyph(4'h1), 8);
        show4(1, glyph(4'h2), 8);
        show4(2, glyph(4'h3), 8);
        c0 = cyc;
        show4(3, glyph(4'h4), 8);
        check("t1_pulses", p4, 32'd1);
        check("t1_fv_edge", fv4_cyc - c0, 32'd6);
        check("t1_code", bus4.code, 32'h4321);
        check("t1_err", bus4.err, 32'h0);

        // 2: 2-cycle glitch before each digit must not be captured
        p4 = 0;
        for (int d = 0; d < 4; d++) begin
            show4(d, glyph(4'h8), 2);
            check("t2_mask_glitch", dut4.mask_q, (1 << d) - 1);
            show4(d, glyph(4'(d + 1)), 1);
            check("t2_cnt_restart", dut4.cnt_q, 32'd0);
            show4(d, glyph(4'(d + 1)), 7);
        end
        check("t2_pulses", p4, 32'd1);
        check("t2_code", bus4.code, 32'h4321);
        check("t2_err", bus4.err, 32'h0);

        // 3: illegal glyph (segment a only) on digit 2
        p4 = 0;
        show4(0, glyph(4'h1), 8);
        show4(1, glyph(4'h2), 8);
        show4(2, 7'b0000001, 8);
        show4(3, glyph(4'h4), 8);
        check("t3_pulses", p4, 32'd1);
        check("t3_code", bus4.code, 32'h4021);
        check("t3_err", bus4.err, 32'b0100);

        // 4: two selects low, then none low
        p4 = 0;
        bus4.seg_n = ~glyph(4'h5);
        bus4.dig_n = 4'b1100;
        repeat (20) step();
        check("t4_cnt_sat", dut4.cnt_q, 32'd3);
        check("t4_mask_multi", dut4.mask_q, 32'h0);
        bus4.dig_n = 4'b1111;
        repeat (20) step();
        check("t4_mask_none", dut4.mask_q, 32'h0);
        check("t4_pulses", p4, 32'd0);
        check("t4_code_hold", bus4.code, 32'h4021);

        // 5: reset after two digits captured
        p4 = 0;
        show4(0, glyph(4'h9), 8);
        show4(1, glyph(4'hA), 8);
        check("t5_mask_partial", dut4.mask_q, 32'b0011);
        rst        = 1'b1;
        bus4.seg_n = 7'h7F;
        bus4.dig_n = 4'hF;
        repeat (2) step();
        check("t5_code", bus4.code, 32'h0);
        check("t5_err", bus4.err, 32'h0);
        check("t5_fv", bus4.frame_valid, 32'h0);
        check("t5_mask", dut4.mask_q, 32'h0);
        rst = 1'b0;
        step();
        show4(0, glyph(4'h5), 8);
        show4(1, glyph(4'h6), 8);
        show4(2, glyph(4'h7), 8);
        show4(3, glyph(4'h8), 8);
        check("t5_pulses", p4, 32'd1);
        check("t5_code_after", bus4.code, 32'h8765);
        check("t5_err_after", bus4.err, 32'h0);

        // 6: round trip through the reference encoder, single digit
        bus1.dig_n = 1'b0;
        for (int v = 0; v < 16; v++) begin
            p1 = 0;
            bus1.seg_n = ~glyph(4'(v));
            repeat (6) step();
            check("t6_err_code", {bus1.err, bus1.code}, 32'(v));
            check("t6_pulses", p1, 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hex_scan_decoder.md
# hex_scan_decoder

Receive-side counterpart of the hex-to-7-segment encoder. Samples the active-low segment lines and active-low digit-select lines of a time-multiplexed multi-digit 7-segment display and recovers the 4-bit hex code behind each digit. Each digit is decoded only after its pattern has been stable for a set number of cycles. Assembles a complete multi-digit word and flags segment patterns that are not one of the 16 legal glyphs. Used for self-checking display paths and for snooping external display buses.

## Interface

**Parameters**
- `N_DIGITS`, default 4: number of multiplexed digits; range 1–8.
- `STABLE`, default 16: consecutive registered cycles a pattern must hold before acceptance; minimum 2.

**Ports** (clock and reset first)
- `clk`  in  1: the block's only clock; all logic on its rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `seg_n`  in  7: active-low segments; bit0 = a … bit6 = g.
- `dig_n`  in  N_DIGITS: active-low digit selects; bit i low selects digit i.
- `code`  out  4*N_DIGITS: decoded word; digit i occupies `code[4i+3:4i]`.
- `err`  out  N_DIGITS: bit i set means digit i showed an illegal pattern in the last frame.
- `frame_valid`  out  1: one-cycle pulse when `code`/`err` update.

## Operation

**Legal glyphs** (active-high segment value `~seg_n`, listed g..a → code):
- 0111111→0, 0000110→1, 1011011→2, 1001111→3
- 1100110→4, 1101101→5, 1111101→6, 0000111→7
- 1111111→8, 1101111→9, 1110111→A, 1111100→B
- 0111001→C, 1011110→D, 1111001→E, 1110001→F
- Any other pattern, including blank, decodes as nibble 0 with the error flag set.

**Input stage**
- `seg_n` and `dig_n` are registered into `seg_q` and `dig_q` on every edge.
- A stability counter `cnt` clears to 0 whenever the newly registered `{seg_q, dig_q}` differs from its previous value.
- Otherwise `cnt` increments, saturating at STABLE-1.

**FSM states**
- **SETTLE**: waiting for a stable pattern.
  - Go to HOLD when `cnt == STABLE-1` and `dig_q` has exactly one bit low.
  - On that transition: write the decoded nibble and error flag for digit i into shadow registers and set `mask[i]`.
- **HOLD**: digit already accepted; no further write.
  - Go to SETTLE when the registered input changes (same edge that clears `cnt`).

**Select and capture rules**
- If `dig_q` is all-high or has two or more bits low, no capture occurs. The FSM stays in SETTLE and `cnt` keeps counting.
- Recapturing digit i before the frame completes overwrites its shadow entry (latest wins).

**Frame completion**
- On the edge after `mask` becomes all-ones:
  - `code` ← shadow nibbles; `err` ← shadow error bits;
  - `frame_valid` ← 1; `mask` ← 0.
- On all other edges `frame_valid` ← 0. `code` and `err` hold between frames.
- A capture on the same edge that clears `mask` sets its mask bit in the new mask (the set wins over the clear). It counts toward the next frame.

**Reset values**
- `code` = 0, `err` = 0, `frame_valid` = 0
- `mask` = 0, shadows = 0, state = SETTLE, `cnt` = 0
- `seg_q` = 7'h7F, `dig_q` = all-ones

**Reset mid-operation:** a partially collected frame is discarded. No `frame_valid` is issued for it.

## Timing

Let edge E be the first edge at which a new pin value is registered.
- Edge E: `cnt` = 0.
- Edge E+k: `cnt` = k, for k < STABLE.
- Edge E+STABLE: shadow written, `mask[i]` set.
- If that capture completes the mask, `frame_valid` is high for exactly one cycle, from edge E+STABLE+1 to edge E+STABLE+2. The `code` update is visible in the same cycle.
- Minimum per-digit dwell for capture: STABLE+1 cycles.
- Maximum frame rate: one frame per N_DIGITS·(STABLE+1) cycles.

## Test plan

Unless stated otherwise: N_DIGITS=4, STABLE=4.

1. **Basic frame:** dig 0..3 show 1, 2, 3, 4 (`seg_n` = ~0000110, ~1011011, ~1001111, ~1100110), 8 cycles each → single `frame_valid` pulse exactly 5 edges after digit 3 registers; `code` = 16'h4321, `err` = 0.
2. **Glitch rejection:** a 2-cycle glitch pattern precedes each valid digit → glitch never captured; `code` = 16'h4321 once; `cnt` restart confirmed.
3. **Illegal glyph:** digit 2 shows `seg_n` = ~0000001 (segment a only) → `code` = 16'h4021, `err` = 4'b0100.
4. **Bad select:** `dig_n` = 4'b1100 held 20 cycles, then 4'b1111 held 20 cycles → no mask bits set, no `frame_valid`.
5. **Reset mid-frame:** assert `rst` after digits 0–1 are captured → outputs 0; a full subsequent frame then yields exactly one pulse with the correct code.
6. **Round-trip sweep:** loop all 16 nibbles through the encoder into the decoder (N_DIGITS=1) → decoded `code` equals the source for every value; `err` = 0.
